// File: rtl/bitstream_self_writer_pkg.sv
// Shared types and helpers for the configuration self-writer.
// Byte lanes fill big-endian: first byte lands in [31:24].
package bitstream_writer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int MAX_WORDS_DEF  = 4096;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } bsw_state_t;

  function automatic logic [31:0] pack_byte(
    input logic [31:0] w,
    input logic [1:0]  idx,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    unique case (idx)
      2'd0: r[31:24] = b;
      2'd1: r[23:16] = b;
      2'd2: r[15:8]  = b;
      2'd3: r[7:0]   = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitstream_self_writer_if.sv
// Byte stream handshake into the self-writer.
// Source drives data/valid/last, writer returns ready.
interface bsw_stream_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/bitstream_self_writer.sv
// Packs a byte stream into 32-bit words and paces them
// onto the fabric self-write port (setup/strobe/hold).
module bitstream_self_writer
  import bitstream_writer_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 2,
  parameter int MAX_WORDS    = MAX_WORDS_DEF,
  localparam int WCW = $clog2(MAX_WORDS + 1)
) (
  input  logic            CLK,
  input  logic            resetn,
  input  logic            start,
  bsw_stream_if.slave     in_s,
  output logic [31:0]     SelfWriteData,
  output logic            SelfWriteStrobe,
  output logic            busy,
  output logic            done,
  output logic            misaligned,
  output logic [WCW-1:0]  word_count
);

  localparam int PMAX =
    (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES
                                 : HOLD_CYCLES;
  localparam int CW = $clog2(PMAX + 1);

  bsw_state_t     state_q;
  logic [1:0]     idx_q;
  logic [31:0]    word_q;
  logic [31:0]    data_q;
  logic [CW-1:0]  cnt_q;
  logic [WCW-1:0] wc_q;
  logic           last_q;
  logic           strobe_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
  logic           mis_q;

  logic        accept;
  logic        fin_d;
  logic [31:0] word_d;

  assign accept = ready_q && in_s.in_valid;
  assign word_d = pack_byte(word_q, idx_q, in_s.in_data);
  assign fin_d  = in_s.in_last ||
                  (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      word_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      wc_q     <= '0;
      last_q   <= 1'b0;
      strobe_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            wc_q    <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept && fin_d) begin
            state_q <= SETUP;
            ready_q <= 1'b0;
            data_q  <= word_d;
            word_q  <= '0;
            last_q  <= in_s.in_last;
            cnt_q   <= CW'(SETUP_CYCLES - 1);
            // short final word: low lanes stay zero
            if (in_s.in_last && idx_q != 2'd3)
              mis_q <= 1'b1;
          end else if (accept) begin
            word_q <= word_d;
            idx_q  <= idx_q + 2'd1;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q  <= STROBE;
            strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          state_q  <= HOLD;
          strobe_q <= 1'b0;
          wc_q     <= wc_q + 1'b1;
          cnt_q    <= CW'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (last_q ||
                       wc_q == WCW'(MAX_WORDS)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
            idx_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_s.in_ready   = ready_q;
  assign SelfWriteData   = data_q;
  assign SelfWriteStrobe = strobe_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign misaligned      = mis_q;
  assign word_count      = wc_q;

endmodule

// File: tb/tb_bitstream_self_writer.sv
// Directed bench for bitstream_self_writer.
// Two instances: default limit and MAX_WORDS = 3.
module tb_bitstream_self_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic start_a;
  logic start_b;

  bsw_stream_if a_if ();
  bsw_stream_if b_if ();

  logic [31:0] data_a, data_b;
  logic        stb_a, stb_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        mis_a, mis_b;
  logic [12:0] wc_a;
  logic [1:0]  wc_b;

  bitstream_self_writer u_a (
    .CLK             (clk),
    .resetn          (rstn),
    .start           (start_a),
    .in_s            (a_if),
    .SelfWriteData   (data_a),
    .SelfWriteStrobe (stb_a),
    .busy            (busy_a),
    .done            (done_a),
    .misaligned      (mis_a),
    .word_count      (wc_a)
  );

  bitstream_self_writer #(.MAX_WORDS(3)) u_b (
    .CLK             (clk),
    .resetn          (rstn),
    .start           (start_b),
    .in_s            (b_if),
    .SelfWriteData   (data_b),
    .SelfWriteStrobe (stb_b),
    .busy            (busy_b),
    .done            (done_b),
    .misaligned      (mis_b),
    .word_count      (wc_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] qa[$];
  int          qa_cyc[$];
  logic [31:0] qb[$];
  logic [31:0] prev_a = '0;
  int          chg_a = 0;
  int          str_a = -1000;
  logic        pstb_a = 1'b0;

  // pacing monitor on the main instance
  always @(negedge clk) begin
    if (data_a !== prev_a) begin
      if (rstn && str_a >= 0) begin
        chk("hold", (cyc - str_a > 2) ? 1 : 0, 1);
        str_a = -1000;
      end
      chg_a  = cyc;
      prev_a = data_a;
    end
    if (pstb_a) chk("stb_width", stb_a, 0);
    if (stb_a && !pstb_a) begin
      if (rstn) chk("setup", cyc - chg_a, 2);
      qa.push_back(data_a);
      qa_cyc.push_back(cyc);
      if (rstn) str_a = cyc;
    end
    if (!rstn) str_a = -1000;
    pstb_a = stb_a;
  end

  always @(negedge clk)
    if (stb_b) qb.push_back(data_b);

  task automatic send(
    input  bit         which,
    input  logic [7:0] b[$],
    input  bit         stall,
    input  int         tmo,
    output int         nacc
  );
    int idle = 0;
    bit tog = 1'b1;
    bit acc;
    nacc = 0;
    while (nacc < b.size() && idle < tmo) begin
      if (which) begin
        b_if.in_data  = b[nacc];
        b_if.in_last  = (nacc == b.size() - 1);
        b_if.in_valid = stall ? tog : 1'b1;
        acc = b_if.in_valid && b_if.in_ready;
      end else begin
        a_if.in_data  = b[nacc];
        a_if.in_last  = (nacc == b.size() - 1);
        a_if.in_valid = stall ? tog : 1'b1;
        acc = a_if.in_valid && a_if.in_ready;
      end
      tog = ~tog;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        idle = 0;
      end else begin
        idle++;
      end
    end
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
  endtask

  task automatic pulse(input bit which);
    if (which) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int tmo);
    int k = 0;
    while (k < tmo && !(which ? done_b : done_a)) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_wait", which ? done_b : done_a, 1);
  endtask

  logic [7:0] s8[$]  = '{8'h01, 8'h02, 8'h03, 8'h04,
                         8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] s6[$]  = '{8'hAA, 8'hBB, 8'hCC,
                         8'hDD, 8'hEE, 8'hFF};
  logic [7:0] s8b[$] = '{8'h11, 8'h22, 8'h33, 8'h44,
                         8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] s20[$];
  int n;

  initial begin
    rstn    = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    a_if.in_data  = '0;
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    b_if.in_data  = '0;
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
    for (int i = 1; i <= 20; i++) s20.push_back(8'(i));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  data_a, 0);
    chk("rst_stb",   stb_a, 0);
    chk("rst_rdy",   a_if.in_ready, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_mis",   mis_a, 0);
    chk("rst_wc",    wc_a, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // aligned 8 bytes
    qa.delete(); qa_cyc.delete();
    pulse(0);
    chk("t1_rdy",  a_if.in_ready, 1);
    chk("t1_busy", busy_a, 1);
    send(0, s8, 0, 100, n);
    wait_done(0, 100);
    chk("t1_n",     qa.size(), 2);
    chk("t1_w0",    qa[0], 32'h01020304);
    chk("t1_w1",    qa[1], 32'h05060708);
    chk("t1_gap",   qa_cyc[1] - qa_cyc[0], 9);
    chk("t1_wc",    wc_a, 2);
    chk("t1_mis",   mis_a, 0);
    chk("t1_busy0", busy_a, 0);
    chk("t1_rdy0",  a_if.in_ready, 0);

    // 6 bytes, short final word
    qa.delete(); qa_cyc.delete();
    pulse(0);
    chk("t2_done0", done_a, 0);
    send(0, s6, 0, 100, n);
    wait_done(0, 100);
    chk("t2_n",   qa.size(), 2);
    chk("t2_w0",  qa[0], 32'hAABBCCDD);
    chk("t2_w1",  qa[1], 32'hEEFF0000);
    chk("t2_mis", mis_a, 1);
    chk("t2_wc",  wc_a, 2);

    // stalled source
    qa.delete(); qa_cyc.delete();
    pulse(0);
    chk("t3_mis0", mis_a, 0);
    send(0, s8, 1, 100, n);
    wait_done(0, 200);
    chk("t3_n",  qa.size(), 2);
    chk("t3_w0", qa[0], 32'h01020304);
    chk("t3_w1", qa[1], 32'h05060708);
    chk("t3_wc", wc_a, 2);

    // word limit on the small instance
    qb.delete();
    pulse(1);
    send(1, s20, 0, 40, n);
    chk("t4_acc",  n, 12);
    chk("t4_n",    qb.size(), 3);
    chk("t4_w2",   qb[2], 32'h090A0B0C);
    chk("t4_wc",   wc_b, 3);
    chk("t4_done", done_b, 1);
    chk("t4_mis",  mis_b, 0);
    chk("t4_rdy",  b_if.in_ready, 0);

    // reset during second strobe
    qa.delete(); qa_cyc.delete();
    pulse(0);
    fork
      send(0, s8, 0, 60, n);
      begin
        int ns = 0;
        for (int k = 0; k < 200 && ns < 2; k++) begin
          @(posedge clk); #1;
          if (stb_a) ns++;
        end
        chk("t5_seen", ns, 2);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("t5_stb",  stb_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_wc",   wc_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_rdy",  a_if.in_ready, 0);
        chk("t5_data", data_a, 0);
        rstn = 1'b1;
      end
    join
    @(posedge clk); #1;
    qa.delete(); qa_cyc.delete();
    pulse(0);
    send(0, s8, 0, 100, n);
    wait_done(0, 100);
    chk("t5_n",  qa.size(), 2);
    chk("t5_w0", qa[0], 32'h01020304);
    chk("t5_w1", qa[1], 32'h05060708);
    chk("t5_wc", wc_a, 2);

    // start while busy is ignored
    qa.delete(); qa_cyc.delete();
    pulse(0);
    fork
      send(0, s8b, 0, 100, n);
      begin
        repeat (2) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
      end
    join
    wait_done(0, 100);
    chk("t6_n",  qa.size(), 2);
    chk("t6_w0", qa[0], 32'h11223344);
    chk("t6_w1", qa[1], 32'h55667788);
    chk("t6_wc", wc_a, 2);
    qa.delete(); qa_cyc.delete();
    pulse(0);
    chk("t6_wc0",   wc_a, 0);
    chk("t6_done0", done_a, 0);
    send(0, s6, 0, 100, n);
    wait_done(0, 100);
    chk("t6_wc2", wc_a, 2);
    chk("t6_w1b", qa[1], 32'hEEFF0000);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bitstream_self_writer.md
# bitstream_self_writer

Hardware replacement for the bench-driven configuration load: accepts a byte stream (from the UART/SPI flash front end or a boot ROM reader) and writes it into the fabric's self-write configuration port as 32-bit words. It drives `SelfWriteData`/`SelfWriteStrobe` with exactly the setup/strobe/hold pacing the configuration FSM expects. It sits beside `eFPGA_top` in the SoC wrapper and owns the self-write port during boot.

## Interface

Parameters:
- `SETUP_CYCLES`, 2, cycles `SelfWriteData` is stable before the strobe (≥1)
- `HOLD_CYCLES`, 2, cycles `SelfWriteData` is held after the strobe (≥1)
- `MAX_WORDS`, 4096, word limit per load (16384 bytes); `WCW = $clog2(MAX_WORDS+1)`

Ports:
- `CLK`  in  1  single clock
- `resetn`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a load from IDLE or DONE
- `in_data`  in  8  stream byte
- `in_valid`  in  1  byte valid
- `in_last`  in  1  marks the final byte of the load (qualified by `in_valid`)
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `SelfWriteData`  out  32  configuration word
- `SelfWriteStrobe`  out  1  one-cycle write strobe
- `busy`  out  1  load in progress
- `done`  out  1  level; load finished
- `misaligned`  out  1  level; last word was zero-padded
- `word_count`  out  WCW  words strobed in the current or last load

## Operation

- Reset values: `SelfWriteData` = 0, `SelfWriteStrobe` = 0, `in_ready` = 0, `busy` = 0, `done` = 0, `misaligned` = 0, `word_count` = 0, state IDLE.
- States:
  - **IDLE**: `start` → COLLECT. Clears `word_count`, `misaligned`, `done` and the byte index.
  - **COLLECT**: `in_ready` = 1. The accepted byte goes to lane `3 - idx`: first byte → [31:24], big-endian. `idx` counts 0..3. On the 4th byte, or on an `in_last` byte, → SETUP.
  - **SETUP**: `SETUP_CYCLES` cycles, then → STROBE.
  - **STROBE**: one cycle with `SelfWriteStrobe` = 1 and `word_count` + 1, then → HOLD.
  - **HOLD**: `HOLD_CYCLES` cycles. Exit goes to DONE if the word carried `in_last` or the new `word_count` == `MAX_WORDS`; otherwise → COLLECT with `idx` = 0.
  - **DONE**: `done` = 1, `in_ready` = 0. `start` → COLLECT with the same clears as IDLE.
- Partial word on `in_last` (`idx` < 3): unfilled low lanes are 0, `misaligned` is set, and the word is still written.
- `start` outside IDLE/DONE is ignored.
- `busy` = 1 in COLLECT, SETUP, STROBE and HOLD.
- Reaching `MAX_WORDS` without `in_last` ends in DONE with `misaligned` = 0. Any further bytes are not accepted.
- `resetn` low mid-load: on the next edge all outputs return to their reset values, including a strobe in progress. No partial word is written.

## Timing

- `in_ready` is registered and is 1 only in COLLECT. Consequently `in_ready` is 0 in the cycle after the accepting edge of the 4th or last byte.
- `SelfWriteData` updates on the edge that enters SETUP. It is constant through SETUP, STROBE and HOLD.
- The strobe is asserted exactly `SETUP_CYCLES` cycles after `SelfWriteData` changes and lasts exactly 1 cycle. `SelfWriteData` then holds for `HOLD_CYCLES` more cycles.
- Minimum word period with back-to-back bytes: 4 + `SETUP_CYCLES` + 1 + `HOLD_CYCLES` = 9 cycles at defaults.
- Minimum gap between strobes: `HOLD_CYCLES` + 4 + `SETUP_CYCLES`.
- `start` → first `in_ready`: 1 cycle.
- `done` rises on the edge that leaves the final HOLD cycle.
- `word_count` increments on the edge that ends STROBE.

## Structure

- Package `bitstream_writer_pkg`:
  - state enum `bsw_state_t` (IDLE, COLLECT, SETUP, STROBE, HOLD, DONE)
  - `BYTES_PER_WORD` = 4
  - default `MAX_WORDS`
- Single module, one FSM plus the pacing counter. No sub-module is warranted because the byte packer is four lane registers. Est. 150–200 lines.
- The SoC integration bench instantiates it ahead of `eFPGA_top`, with a ROM model feeding `in_*`.

## Test plan

- **8 aligned bytes.** Stream 01 02 03 04 05 06 07 08 with `in_last` on 08. Required:
  - two strobes, data 0x01020304 then 0x05060708
  - 9-cycle word spacing
  - `word_count` = 2, `done` = 1, `misaligned` = 0
- **6 bytes with `in_last`.** Stream AA BB CC DD EE FF. Required: second word 0xEEFF0000 and `misaligned` = 1.
- **Stalled source.** `in_valid` toggles 1/0 each cycle. Required: same words as the aligned case, strobe pulses exactly 1 cycle, and data stable from 2 cycles before to 2 cycles after each strobe.
- **Word limit.** `MAX_WORDS` = 3 with a 20-byte stream. Required: exactly 3 strobes, `done` = 1, and byte 13 never accepted.
- **Reset mid-load.** `resetn` low in the STROBE cycle of word 2. Required: next edge gives `SelfWriteStrobe` = 0, `busy` = 0, `word_count` = 0, state IDLE. A new `start` then reloads correctly.
- **Start ignored while busy.** `start` pulses during COLLECT have no effect. After DONE, a second `start` runs a fresh load with `word_count` restarting at 0.
